// File: rtl/histogram_ctrl.sv
// rtl/histogram_ctrl.sv - histogram acquisition controller: clear, accumulate samples, read out bins
module histogram_ctrl #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] n_samples,
  input  logic          smp_valid,
  input  logic [AW-1:0] smp_bin,
  output logic          smp_ready,
  output logic          hist_clr_n,
  output logic [AW-1:0] hist_addr,
  output logic          hist_rw,
  input  logic [DW-1:0] hist_dout,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_bin,
  output logic [DW-1:0] rd_count,
  output logic          rd_last,
  output logic [DW-1:0] acq_count,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACQ,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_HOLD,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_BIN = '1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);

  state_t        state_q, state_d;
  logic [DW-1:0] n_lat_q, n_lat_d;
  logic [DW-1:0] acq_q, acq_d;
  logic [DW-1:0] rd_count_q, rd_count_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          accept;

  // A sample is taken only while acquiring and not being cancelled.
  assign smp_ready = (state_q == S_ACQ) & ~abort;
  assign accept    = smp_valid & smp_ready;

  // State register and run datapath; reset drops everything back to idle at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_lat_q    <= '0;
      acq_q      <= '0;
      rd_count_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_lat_q    <= n_lat_d;
      acq_q      <= acq_d;
      rd_count_q <= rd_count_d;
      ptr_q      <= ptr_d;
    end
  end

  // Next-state and datapath updates; abort outranks every other transition.
  always_comb begin
    state_d    = state_q;
    n_lat_d    = n_lat_q;
    acq_d      = acq_q;
    rd_count_d = rd_count_q;
    ptr_d      = ptr_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_CLEAR;
            n_lat_d = n_samples;
            acq_d   = '0;
            ptr_d   = '0;
          end
        end
        S_CLEAR: begin
          state_d = (n_lat_q == '0) ? S_RD_ADDR : S_ACQ;
        end
        S_ACQ: begin
          if (accept) begin
            acq_d = acq_q + CNT_ONE;
            if ((acq_q + CNT_ONE) == n_lat_q) begin
              state_d = S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          state_d = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // Memory read data lands one cycle after the address was presented.
          rd_count_d = hist_dout;
          state_d    = S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (rd_ready) begin
            if (ptr_q == LAST_BIN) begin
              state_d = S_DONE;
            end else begin
              ptr_d   = ptr_q + PTR_ONE;
              state_d = S_RD_ADDR;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Memory control and readout outputs decoded from the current state.
  always_comb begin
    hist_clr_n = (state_q != S_CLEAR);
    hist_rw    = ~accept;
    hist_addr  = '0;
    if (accept) begin
      hist_addr = smp_bin;
    end else if (state_q == S_RD_ADDR || state_q == S_RD_WAIT) begin
      hist_addr = ptr_q;
    end
    rd_valid  = (state_q == S_RD_HOLD);
    rd_bin    = ptr_q;
    rd_count  = rd_count_q;
    rd_last   = (state_q == S_RD_HOLD) && (ptr_q == LAST_BIN);
    acq_count = acq_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_histogram_ctrl.sv
// tb/tb_histogram_ctrl.sv - self-checking bench for histogram_ctrl with a histogram memory model
module tb_histogram_ctrl;
  localparam int AW   = 2;
  localparam int DW   = 16;
  localparam int NPOS = 4;

  typedef struct {
    int bin;
    int cnt;
    int last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] n_samples = '0;
  logic          smp_valid = 1'b0;
  logic [AW-1:0] smp_bin = '0;
  logic          smp_ready;
  logic          hist_clr_n;
  logic [AW-1:0] hist_addr;
  logic          hist_rw;
  logic [DW-1:0] hist_dout;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [AW-1:0] rd_bin;
  logic [DW-1:0] rd_count;
  logic          rd_last;
  logic [DW-1:0] acq_count;
  logic          busy;
  logic          done;

  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   clr_cnt = 0;
  int   rdy_cnt = 0;
  exp_t exp_q[$];
  int   stim_bins[$];
  exp_t mon_e;
  logic [DW-1:0] mem [NPOS];

  histogram_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_samples(n_samples),
    .smp_valid(smp_valid), .smp_bin(smp_bin), .smp_ready(smp_ready),
    .hist_clr_n(hist_clr_n), .hist_addr(hist_addr), .hist_rw(hist_rw),
    .hist_dout(hist_dout), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_bin(rd_bin), .rd_count(rd_count), .rd_last(rd_last),
    .acq_count(acq_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Histogram memory: synchronous clear, increment-on-write, registered read.
  always @(posedge clk) begin
    if (!hist_clr_n) begin
      for (int i = 0; i < NPOS; i++) mem[i] <= '0;
    end else if (!hist_rw) begin
      mem[hist_addr] <= mem[hist_addr] + 16'd1;
    end
    hist_dout <= mem[hist_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Readout scoreboard and event counters.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected_bin", int'(rd_bin), -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_bin", int'(rd_bin), mon_e.bin);
          check("rd_count", int'(rd_count), mon_e.cnt);
          check("rd_last", int'(rd_last), mon_e.last);
        end
      end
      if (done) done_cnt++;
      if (!hist_clr_n) clr_cnt++;
      if (smp_ready) rdy_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, input bit expect_rd);
    int   h[NPOS];
    exp_t e;
    for (int i = 0; i < NPOS; i++) h[i] = 0;
    for (int i = 0; i < n; i++) h[stim_bins[i]]++;
    if (expect_rd) begin
      for (int i = 0; i < NPOS; i++) begin
        e.bin = i; e.cnt = h[i]; e.last = (i == NPOS - 1) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
    tick();
    start = 1'b1;
    n_samples = DW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_samples(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      smp_valid = 1'b1;
      smp_bin = AW'(stim_bins[k]);
      t = 0;
      @(negedge clk);
      while (!smp_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check("smp_ready_timeout", 0, 1);
      check("hist_rw_on_accept", int'(hist_rw), 0);
      check("hist_addr_on_accept", int'(hist_addr), stim_bins[k]);
      tick();
    end
    smp_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    int base = done_cnt;
    while (done_cnt == base && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 300) check("done_timeout", 0, 1);
  endtask

  task automatic wait_rd_valid();
    int t = 0;
    @(negedge clk);
    while (!rd_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("rd_valid_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_smp_ready"}, int'(smp_ready), 0);
    check({tag, "_hist_clr_n"}, int'(hist_clr_n), 1);
    check({tag, "_hist_rw"}, int'(hist_rw), 1);
    check({tag, "_hist_addr"}, int'(hist_addr), 0);
    check({tag, "_rd_valid"}, int'(rd_valid), 0);
    check({tag, "_rd_bin"}, int'(rd_bin), 0);
    check({tag, "_rd_count"}, int'(rd_count), 0);
    check({tag, "_rd_last"}, int'(rd_last), 0);
    check({tag, "_acq_count"}, int'(acq_count), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0, r0, hb, hc, hl;

    // Reset state
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    tick();
    rst = 1'b1;
    rd_ready = 1'b1;

    // Basic run: bins 1,1,3,1 back-to-back
    stim_bins = '{1, 1, 3, 1};
    d0 = done_cnt; c0 = clr_cnt;
    start_run(4, 1'b1);
    check("t1_clear_low", int'(hist_clr_n), 0);
    check("t1_busy", int'(busy), 1);
    send_samples(4);
    wait_done();
    check("t1_acq_count", int'(acq_count), 4);
    tick();
    check("t1_done_single", int'(done), 0);
    check("t1_busy_idle", int'(busy), 0);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_clear_cycles", clr_cnt - c0, 1);
    check("t1_queue_empty", exp_q.size(), 0);

    // Zero-sample run
    stim_bins = '{};
    d0 = done_cnt; r0 = rdy_cnt;
    smp_valid = 1'b1;
    smp_bin = '0;
    start_run(0, 1'b1);
    wait_done();
    smp_valid = 1'b0;
    check("t2_no_ready", rdy_cnt - r0, 0);
    check("t2_acq_count", int'(acq_count), 0);
    check("t2_done_pulses", done_cnt - d0, 1);
    tick();
    check("t2_queue_empty", exp_q.size(), 0);

    // Readout backpressure
    stim_bins = '{2, 2};
    rd_ready = 1'b0;
    start_run(2, 1'b1);
    send_samples(2);
    wait_rd_valid();
    hb = int'(rd_bin); hc = int'(rd_count); hl = int'(rd_last);
    check("t3_first_bin", hb, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("t3_hold_valid", int'(rd_valid), 1);
      check("t3_hold_bin", int'(rd_bin), hb);
      check("t3_hold_count", int'(rd_count), hc);
      check("t3_hold_last", int'(rd_last), hl);
    end
    tick();
    rd_ready = 1'b1;
    tick();
    check("t3_advance", int'(rd_valid), 0);
    wait_done();
    tick();
    check("t3_queue_empty", exp_q.size(), 0);

    // Abort coincident with a sample
    stim_bins = '{1, 2, 0};
    d0 = done_cnt;
    start_run(3, 1'b0);
    send_samples(1);
    smp_valid = 1'b1;
    smp_bin = 2'd2;
    abort = 1'b1;
    #1;
    check("t4_ready_low", int'(smp_ready), 0);
    check("t4_rw_read", int'(hist_rw), 1);
    tick();
    abort = 1'b0;
    smp_valid = 1'b0;
    check("t4_idle", int'(busy), 0);
    check("t4_acq_count", int'(acq_count), 1);
    tick();
    tick();
    check("t4_no_done", done_cnt - d0, 0);

    // Reset mid-readout, then a fresh complete run
    stim_bins = '{3};
    rd_ready = 1'b0;
    start_run(1, 1'b1);
    send_samples(1);
    wait_rd_valid();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t5_midrd");
    exp_q.delete();
    tick();
    rst = 1'b1;
    rd_ready = 1'b1;
    stim_bins = '{0, 3, 3};
    d0 = done_cnt;
    start_run(3, 1'b1);
    send_samples(3);
    wait_done();
    check("t5_acq_count", int'(acq_count), 3);
    tick();
    check("t5_done_pulses", done_cnt - d0, 1);
    check("t5_queue_empty", exp_q.size(), 0);

    // Start ignored while busy; n_samples change after start has no effect
    stim_bins = '{1, 2};
    d0 = done_cnt;
    start_run(2, 1'b1);
    n_samples = 16'd7;
    start = 1'b1;
    send_samples(2);
    tick();
    tick();
    check("t6_busy_readout", int'(busy), 1);
    start = 1'b0;
    wait_done();
    check("t6_acq_count", int'(acq_count), 2);
    tick();
    tick();
    check("t6_stays_idle", int'(busy), 0);
    check("t6_done_pulses", done_cnt - d0, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/histogram_ctrl.md
HISTOGRAM_CTRL -- requirements
Module: histogram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, histogram memory address width (NPOS = 2**AW bins).
REQ-002 SHALL have parameter DW, default 16, bin count and sample-count width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  run request; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel run; returns to IDLE.
REQ-007 SHALL have port n_samples  input  DW  samples to accumulate; latched on accepted start.
REQ-008 SHALL have port smp_valid  input  1  sample available.
REQ-009 SHALL have port smp_bin  input  AW  bin index of sample.
REQ-010 SHALL have port smp_ready  output  1  controller accepts sample.
REQ-011 SHALL have port hist_clr_n  output  1  active-low clear to histogram memory.
REQ-012 SHALL have port hist_addr  output  AW  histogram memory address.
REQ-013 SHALL have port hist_rw  output  1  memory mode: 1 read, 0 increment bin.
REQ-014 SHALL have port hist_dout  input  DW  registered memory read data (1-cycle latency).
REQ-015 SHALL have port rd_valid / rd_ready  output / input  1 / 1  readout handshake.
REQ-016 SHALL have port rd_bin / rd_count / rd_last  output  AW / DW / 1  readout bin, its count, final-bin flag.
REQ-017 SHALL have port acq_count  output  DW  samples accepted in current run.
REQ-018 SHALL have ports busy, done  output  1 each  busy = state not IDLE; done = one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, ACQ, RD_ADDR, RD_WAIT, RD_HOLD, DONE.
REQ-020 SHALL move IDLE->CLEAR on start=1 and abort=0, latching n_samples and zeroing acq_count and read pointer.
REQ-021 SHALL drive hist_clr_n=0 for exactly the one CLEAR cycle, 1 otherwise; CLEAR->ACQ, or CLEAR->RD_ADDR when latched n_samples=0.
REQ-022 SHALL drive smp_ready = (state==ACQ) & ~abort, combinationally.
REQ-023 SHALL, on accepted sample (smp_valid & smp_ready), drive hist_rw=0 and hist_addr=smp_bin combinationally that cycle and increment acq_count; hist_rw=1 in every other cycle.
REQ-024 SHALL move ACQ->RD_ADDR on the accepted sample that makes acq_count equal latched n_samples; no further samples accepted.
REQ-025 SHALL accept back-to-back samples every cycle, including repeated identical bins.
REQ-026 SHALL in RD_ADDR drive hist_addr=read pointer, hist_rw=1, go to RD_WAIT; in RD_WAIT hold hist_addr and register hist_dout into rd_count, go to RD_HOLD.
REQ-027 SHALL in RD_HOLD assert rd_valid with rd_bin=read pointer and rd_count, rd_last=1 iff pointer=NPOS-1, all stable until rd_ready=1.
REQ-028 SHALL on RD_HOLD with rd_ready=1: if pointer=NPOS-1 go to DONE, else increment pointer and go to RD_ADDR (3 cycles/bin minimum).
REQ-029 SHALL assert done for the single DONE cycle, then return to IDLE; acq_count retained until next start.
REQ-030 SHALL on abort=1 in any non-IDLE state go to IDLE next edge, with no done pulse and no sample accepted that cycle.
REQ-031 SHALL ignore start outside IDLE and ignore start while abort=1.

Reset
REQ-032 SHALL on rst=0 immediately force IDLE, smp_ready=0, hist_clr_n=1, hist_rw=1, hist_addr=0, rd_valid=0, rd_bin=0, rd_count=0, rd_last=0, acq_count=0, busy=0, done=0, regardless of state (including mid-ACQ or mid-readout).

Verification
REQ-033 SHALL verify: AW=2, n_samples=4, bins 1,1,3,1 back-to-back, rd_ready=1 -> one hist_clr_n low cycle; readout (0,0),(1,3),(2,0),(3,1), rd_last on bin 3, single done pulse.
REQ-034 SHALL verify: n_samples=0 -> no smp_ready; readout of NPOS zero bins; done.
REQ-035 SHALL verify: rd_ready held 0 for 5 cycles in RD_HOLD -> rd_valid, rd_bin, rd_count stable; advances one cycle after rd_ready=1.
REQ-036 SHALL verify: abort coincident with smp_valid in ACQ -> sample not counted, IDLE next cycle, no done.
REQ-037 SHALL verify: rst low mid-readout -> all outputs at reset values immediately; new start runs full clear/acquire/readout correctly.
REQ-038 SHALL verify: start pulses during ACQ and readout -> ignored; n_samples change after start -> no effect on run length.
